// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_arbiter
// Description : Shares one backing-memory port between I-cache refill, D-cache
//               writeback and D-cache refill, sequencing one word per beat.
//               Optional ARB_ROUND_ROBIN_EN macro enables I/D round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
    parameter int IC_WORDS = 8,
    parameter int DC_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ic_req,
    input  logic [31:0]                 ic_addr,
    output logic                        ic_valid,
    output logic [$clog2(IC_WORDS)-1:0] ic_beat,
    output logic                        ic_done,
    input  logic                        dc_wb_req,
    input  logic [31:0]                 dc_wb_addr,
    input  logic [31:0]                 dc_wb_data,
    input  logic                        dc_fill_req,
    input  logic [31:0]                 dc_fill_addr,
    output logic                        dc_valid,
    output logic [$clog2(DC_WORDS)-1:0] dc_beat,
    output logic                        dc_done,
    output logic [31:0]                 rd_data,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata
);

    localparam int c_IC_BW = $clog2(IC_WORDS);
    localparam int c_DC_BW = $clog2(DC_WORDS);
    localparam int c_BW    = (c_IC_BW > c_DC_BW) ? c_IC_BW : c_DC_BW;

    localparam logic [31:0]     c_IC_MASK = ~(32'(IC_WORDS * 4) - 32'd1);
    localparam logic [31:0]     c_DC_MASK = ~(32'(DC_WORDS * 4) - 32'd1);
    localparam logic [c_BW-1:0] c_IC_LAST = c_BW'(IC_WORDS - 1);
    localparam logic [c_BW-1:0] c_DC_LAST = c_BW'(DC_WORDS - 1);
    localparam logic [c_BW-1:0] c_ONE     = c_BW'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_D_WB   = 2'd1;
    localparam logic [1:0] c_D_FILL = 2'd2;
    localparam logic [1:0] c_I_FILL = 2'd3;

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_beat;
    logic [31:0]     r_base;

    logic        w_active;
    logic        w_last;
    logic        w_line_end;
    logic        w_chain;
    logic        w_d_pending;
    logic        w_pick_d;
    logic [1:0]  w_grant_state;
    logic [31:0] w_grant_base;

    assign w_active    = (r_state != c_IDLE);
    assign w_last      = (r_state == c_I_FILL) ? (r_beat == c_IC_LAST) : (r_beat == c_DC_LAST);
    assign w_line_end  = w_active && mem_ack && w_last;
    // A fill waiting behind a writeback follows it without returning to IDLE.
    assign w_chain     = (r_state == c_D_WB) && dc_fill_req;
    assign w_d_pending = dc_wb_req || dc_fill_req;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic c_OWNER_I = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    logic r_last_owner;

    // D side yields only when the I-cache is waiting and D owned the port last.
    assign w_pick_d = w_d_pending && !(ic_req && (r_last_owner == c_OWNER_D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= c_OWNER_I;
        end else if (w_line_end && !w_chain) begin
            r_last_owner <= (r_state == c_I_FILL) ? c_OWNER_I : c_OWNER_D;
        end
    end
`else
    assign w_pick_d = w_d_pending;
`endif

    always_comb begin
        w_grant_state = c_IDLE;
        w_grant_base  = r_base;
        if (w_pick_d && dc_wb_req) begin
            w_grant_state = c_D_WB;
            w_grant_base  = dc_wb_addr & c_DC_MASK;
        end else if (w_pick_d && dc_fill_req) begin
            w_grant_state = c_D_FILL;
            w_grant_base  = dc_fill_addr & c_DC_MASK;
        end else if (ic_req) begin
            w_grant_state = c_I_FILL;
            w_grant_base  = ic_addr & c_IC_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_beat  <= '0;
            r_base  <= '0;
        end else if (r_state == c_IDLE) begin
            r_state <= w_grant_state;
            r_base  <= w_grant_base;
            r_beat  <= '0;
        end else if (mem_ack) begin
            if (w_last) begin
                r_beat <= '0;
                if (w_chain) begin
                    r_state <= c_D_FILL;
                    r_base  <= dc_fill_addr & c_DC_MASK;
                end else begin
                    r_state <= c_IDLE;
                end
            end else begin
                r_beat <= r_beat + c_ONE;
            end
        end
    end

    assign mem_req   = w_active;
    assign mem_we    = (r_state == c_D_WB);
    assign mem_addr  = w_active ? (r_base + {{(30-c_BW){1'b0}}, r_beat, 2'b00}) : 32'd0;
    assign mem_wdata = mem_we ? dc_wb_data : 32'd0;

    assign ic_valid = (r_state == c_I_FILL) && mem_ack;
    assign dc_valid = (r_state == c_D_FILL) && mem_ack;
    assign ic_beat  = (r_state == c_I_FILL) ? r_beat[c_IC_BW-1:0] : '0;
    assign dc_beat  = ((r_state == c_D_WB) || (r_state == c_D_FILL)) ? r_beat[c_DC_BW-1:0] : '0;
    assign ic_done  = ic_valid && w_last;
    assign dc_done  = (dc_valid || (mem_we && mem_ack && !dc_fill_req)) && w_last;
    assign rd_data  = ((r_state == c_I_FILL) || (r_state == c_D_FILL)) ? mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Arbitrates the single backing-memory port between I-cache line refill, D-cache dirty-line writeback and D-cache line refill.
- Sequences multi-word bursts (one word per beat) and returns read beats to the owning cache.
- Sits between the cache FSMs and the main memory.
- The owning cache's stall stays high until that cache sees its DONE pulse.

Parameters:
- IC_WORDS, 8, words per I-cache line (power of 2).
- DC_WORDS, 4, words per D-cache line (power of 2).

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IC_REQ  in  1  I-cache refill request, held until IC_DONE
- IC_ADDR  in  32  I-cache miss byte address; line-aligned internally
- IC_VALID  out  1  I-cache read beat valid
- IC_BEAT  out  $clog2(IC_WORDS)  word index of current I-cache beat
- IC_DONE  out  1  one-cycle pulse on last I-cache beat
- DC_WB_REQ  in  1  D-cache writeback request
- DC_WB_ADDR  in  32  victim line address
- DC_WB_DATA  in  32  writeback word selected by DC_BEAT
- DC_FILL_REQ  in  1  D-cache refill request
- DC_FILL_ADDR  in  32  D-cache miss byte address
- DC_VALID  out  1  D-cache read beat valid
- DC_BEAT  out  $clog2(DC_WORDS)  word index of current D-cache beat (read or write)
- DC_DONE  out  1  pulse on last beat of a fill, or of a writeback with no fill pending
- RD_DATA  out  32  MEM_RDATA passthrough, shared by both caches
- MEM_REQ  out  1  memory beat request
- MEM_WE  out  1  1 = write beat
- MEM_ADDR  out  32  word-aligned beat address
- MEM_WDATA  out  32  write data (DC_WB_DATA)
- MEM_ACK  in  1  beat accepted/complete; read data valid this cycle
- MEM_RDATA  in  32  read data

Behaviour:
- Reset (RST_N low, async): state = IDLE, beat counter = 0, grant registers cleared. All outputs 0 while reset is held and in the first cycle after release.
- States: IDLE, D_WB, D_FILL, I_FILL.
- IDLE, request sampling:
  - REQ inputs are sampled only in IDLE.
  - Priority: DC_WB_REQ > DC_FILL_REQ > IC_REQ.
  - On a winner, the line base (addr with low $clog2(WORDS)+2 bits cleared) is latched, beat = 0, and the FSM moves to the chosen state.
  - No MEM_REQ is issued in IDLE, so there is a minimum 1-cycle bubble between transactions.
- Active states:
  - MEM_REQ = 1; MEM_ADDR = base + 4*beat.
  - MEM_WE = 1 only in D_WB; MEM_WDATA = DC_WB_DATA.
  - A beat completes on any cycle with MEM_ACK = 1; beat then increments.
  - MEM_REQ stays high back-to-back, so single-cycle beats are allowed.
  - Address and WE stay stable while ACK is low.
- Read beats:
  - IC_VALID = MEM_ACK in I_FILL; DC_VALID = MEM_ACK in D_FILL.
  - RD_DATA = MEM_RDATA combinationally, with IC_BEAT/DC_BEAT = beat index.
- D_WB last beat:
  - If DC_FILL_REQ = 1: go directly to D_FILL. Latch DC_FILL_ADDR, beat = 0, no bubble, no DC_DONE.
  - Else: assert DC_DONE and go to IDLE.
- D_FILL / I_FILL last beat: assert the matching DONE the same cycle, then go to IDLE.
- Requests are not cancellable. Dropping REQ mid-burst is ignored and the burst completes.
- A REQ still high in the cycle after DONE is a new request.
- Simultaneous requests: a loser stays pending, with no loss, until IDLE is re-entered.
- Beat counter wraps to 0 on the last beat; no access crosses a line boundary.
- MEM_ACK in IDLE is ignored.
- Reset mid-burst aborts immediately; the memory is expected to be reset with the same RST_N.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner flag (reset = I) records the owner of the last completed transaction: I = I-cache, D = D-cache (WB or fill).
  - In IDLE, with both an I-cache request and any D-cache request pending, the side that is not last_owner wins.
  - Within the D side, WB still precedes FILL.
- Undefined: fixed priority as above; an I-cache request can starve under continuous D traffic.

Test Plan:
- IC_REQ=1, IC_ADDR=0x0000_0134, MEM_ACK always 1 -> MEM_ADDR 0x120,0x124,...,0x13C on 8 consecutive cycles; IC_VALID 8 cycles, IC_BEAT 0..7; IC_DONE on 8th beat; IDLE next cycle.
- DC_WB_REQ=1 (addr 0x200) and DC_FILL_REQ=1 (addr 0x310), ACK always 1 -> 4 write beats 0x200..0x20C with MEM_WE=1, then 0x310..0x31C reads with no bubble; single DC_DONE on last read beat.
- MEM_ACK toggling 0/1 during I_FILL at 0x40 -> MEM_ADDR held while ACK=0; beat count advances only on ACK; total 8 IC_VALID pulses.
- IC_REQ, DC_FILL_REQ rise same cycle -> D_FILL first. Fixed mode: I_FILL starts after DC_DONE + 1 bubble cycle. Round-robin with a DC request reasserted at DC_DONE: I wins the next IDLE.
- RST_N low during beat 2 of I_FILL -> MEM_REQ, IC_VALID, IC_DONE drop to 0 immediately; after release a new IC_REQ restarts at beat 0.
- IC_REQ dropped after beat 1 -> all 8 beats still issued and IC_DONE pulses.
